ks_xor_stage: RTL and testbench

//  Downstream consumer of the keystream substitution stage `s`, which maps a 32-bit state to an 8-bit keystream byte.

---
 rtl/stream_cipher_pkg.sv | 15 +
 rtl/byte_out_reg.sv | 37 +++
 rtl/ks_xor_stage.sv | 96 +++++++++
 tb/tb_ks_xor_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_cipher_pkg.sv
// rtl/stream_cipher_pkg.sv - shared types and constants for the keystream XOR stage
package stream_cipher_pkg;

   // Default width of message length and byte counter
   localparam int LEN_W_DEF = 16;

   typedef logic [7:0] byte_t;

   // Framing FSM encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/byte_out_reg.sv
// rtl/byte_out_reg.sv - one-deep ciphertext register slice (data + last, valid/ready)
module byte_out_reg
   import stream_cipher_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  load,
   input  byte_t load_data,
   input  logic  load_last,
   input  logic  out_ready,
   output byte_t out_data,
   output logic  out_valid,
   output logic  out_last
);

   // Load wins over drain so a byte can enter while the previous one leaves;
   // data/last are only written on load, so they hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_data  <= load_data;
         out_last  <= load_last;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/ks_xor_stage.sv
// rtl/ks_xor_stage.sv - XORs plaintext with keystream bytes and frames the message
module ks_xor_stage
   import stream_cipher_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len_i,
   input  logic             abort,
   input  logic [7:0]       ks_byte,
   output logic             ks_advance,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] byte_cnt
);

   state_t           state_q;
   logic [LEN_W-1:0] len_q;
   logic             accept;
   logic             is_last;
   logic             handshake;

   // Abort masks acceptance so the keystream is not stepped on the abort cycle
   assign in_ready   = (state_q == ST_RUN) && !abort && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign ks_advance = accept;
   assign is_last    = (byte_cnt == len_q - LEN_W'(1));
   assign handshake  = out_valid && out_ready;
   assign busy       = (state_q != ST_IDLE);

   // Framing FSM, byte counter and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         byte_cnt <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state_q  <= ST_IDLE;
            byte_cnt <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     byte_cnt <= '0;
                     if (len_i != '0) begin
                        len_q   <= len_i;
                        state_q <= ST_RUN;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               ST_RUN: begin
                  if (accept) begin
                     byte_cnt <= byte_cnt + LEN_W'(1);
                     if (is_last) state_q <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  if (handshake) begin
                     state_q <= ST_IDLE;
                     done    <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   byte_out_reg u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (abort),
      .load      (accept),
      .load_data (in_data ^ ks_byte),
      .load_last (is_last),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_ks_xor_stage.sv
// tb/tb_ks_xor_stage.sv - directed self-checking bench for ks_xor_stage
module tb_ks_xor_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] len_i;
   logic        abort;
   logic [7:0]  ks_byte;
   logic        ks_advance;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic [15:0] byte_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] ks_seed;
   logic [7:0] ks_off;
   logic       ks_clr;

   always #5 clk = ~clk;

   // Upstream state generator: steps once per ks_advance
   always @(posedge clk) begin
      if (ks_clr)          ks_off <= 8'd0;
      else if (ks_advance) ks_off <= ks_off + 8'd1;
   end
   assign ks_byte = ks_seed + ks_off;

   ks_xor_stage #(.LEN_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len_i      (len_i),
      .abort      (abort),
      .ks_byte    (ks_byte),
      .ks_advance (ks_advance),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .byte_cnt   (byte_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic seed_ks(input logic [7:0] s);
      ks_seed = s;
      ks_clr  = 1'b1;
      step();
      ks_clr  = 1'b0;
   endtask

   task automatic begin_msg(input logic [15:0] n);
      start = 1'b1;
      len_i = n;
      step();
      start = 1'b0;
   endtask

   logic [7:0] exp2 [4];

   initial begin
      rst_n = 1'b0; start = 1'b0; len_i = '0; abort = 1'b0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      ks_seed = 8'h00; ks_clr = 1'b1;
      exp2[0] = 8'h5D; exp2[1] = 8'h5C; exp2[2] = 8'h5B; exp2[3] = 8'h5A;
      step();
      step();
      #1;
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_last",  32'(out_last),  32'h0);
      chk("rst_done",      32'(done),      32'h0);
      chk("rst_byte_cnt",  32'(byte_cnt),  32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'h0);
      chk("rst_ks_adv",    32'(ks_advance), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // 1: single byte message
      seed_ks(8'hA2);
      begin_msg(16'd1);
      chk("t1_busy", 32'(busy), 32'h1);
      in_data = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("t1_in_ready", 32'(in_ready), 32'h1);
      chk("t1_ks_adv",   32'(ks_advance), 32'h1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("t1_out_data",  32'(out_data),  32'hA2);
      chk("t1_out_valid", 32'(out_valid), 32'h1);
      chk("t1_out_last",  32'(out_last),  32'h1);
      chk("t1_drain_rdy", 32'(in_ready),  32'h0);
      chk("t1_no_done",   32'(done),      32'h0);
      step();
      chk("t1_done",      32'(done),      32'h1);
      chk("t1_idle",      32'(busy),      32'h0);
      chk("t1_valid_clr", 32'(out_valid), 32'h0);
      step();
      chk("t1_done_pulse", 32'(done), 32'h0);

      // 2: four bytes back-to-back
      seed_ks(8'hA2);
      begin_msg(16'd4);
      in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_ks_adv", 32'(ks_advance), 32'h1);
         step();
         chk("t2_out_data",  32'(out_data),  32'(exp2[i]));
         chk("t2_out_valid", 32'(out_valid), 32'h1);
         chk("t2_out_last",  32'(out_last),  (i == 3) ? 32'h1 : 32'h0);
      end
      in_valid = 1'b0;
      chk("t2_byte_cnt", 32'(byte_cnt), 32'd4);
      step();
      chk("t2_done", 32'(done), 32'h1);

      // 3: downstream stall after the first byte
      seed_ks(8'h10);
      begin_msg(16'd3);
      in_data = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("t3_b0", 32'(out_data), 32'h11);
      in_data = 8'h02; out_ready = 1'b0;
      #1;
      chk("t3_stall_rdy", 32'(in_ready),   32'h0);
      chk("t3_stall_adv", 32'(ks_advance), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_hold_data",  32'(out_data),  32'h11);
         chk("t3_hold_valid", 32'(out_valid), 32'h1);
         chk("t3_hold_adv",   32'(ks_advance), 32'h0);
      end
      chk("t3_hold_cnt", 32'(byte_cnt), 32'd1);
      out_ready = 1'b1;
      #1;
      chk("t3_resume_rdy", 32'(in_ready), 32'h1);
      step();
      chk("t3_b1", 32'(out_data), 32'h13);
      chk("t3_b1_last", 32'(out_last), 32'h0);
      in_data = 8'h03;
      step();
      in_valid = 1'b0;
      chk("t3_b2", 32'(out_data), 32'h11);
      chk("t3_b2_last", 32'(out_last), 32'h1);
      step();
      chk("t3_done", 32'(done), 32'h1);

      // 4: zero-length start
      start = 1'b1; len_i = 16'd0;
      step();
      start = 1'b0;
      chk("t4_done",  32'(done),      32'h1);
      chk("t4_busy",  32'(busy),      32'h0);
      chk("t4_valid", 32'(out_valid), 32'h0);
      step();
      chk("t4_done_pulse", 32'(done), 32'h0);
      chk("t4_busy2",      32'(busy), 32'h0);

      // 5: abort after two of five bytes, then a fresh message
      seed_ks(8'h20);
      begin_msg(16'd5);
      in_data = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      step();
      step();
      chk("t5_cnt2", 32'(byte_cnt), 32'd2);
      abort = 1'b1;
      #1;
      chk("t5_abort_adv", 32'(ks_advance), 32'h0);
      step();
      abort = 1'b0; in_valid = 1'b0;
      chk("t5_busy",  32'(busy),      32'h0);
      chk("t5_valid", 32'(out_valid), 32'h0);
      chk("t5_last",  32'(out_last),  32'h0);
      chk("t5_cnt",   32'(byte_cnt),  32'h0);
      chk("t5_done",  32'(done),      32'h0);
      step();
      chk("t5_no_done", 32'(done), 32'h0);
      seed_ks(8'h30);
      begin_msg(16'd2);
      in_data = 8'h0F; in_valid = 1'b1;
      step();
      chk("t5_new_b0", 32'(out_data), 32'h3F);
      in_data = 8'hF0;
      step();
      in_valid = 1'b0;
      chk("t5_new_b1",   32'(out_data), 32'hC1);
      chk("t5_new_last", 32'(out_last), 32'h1);
      step();
      chk("t5_new_done", 32'(done), 32'h1);

      // 6: start ignored while busy, then async reset mid-message
      seed_ks(8'h40);
      begin_msg(16'd4);
      in_data = 8'h00; in_valid = 1'b1;
      step();
      start = 1'b1; len_i = 16'd2;
      step();
      start = 1'b0;
      chk("t6_no_relatch_last", 32'(out_last), 32'h0);
      chk("t6_cnt",  32'(byte_cnt), 32'd2);
      chk("t6_busy", 32'(busy),     32'h1);
      chk("t6_b1",   32'(out_data), 32'h41);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'h0);
      chk("t6_rst_data",  32'(out_data),  32'h0);
      chk("t6_rst_cnt",   32'(byte_cnt),  32'h0);
      chk("t6_rst_busy",  32'(busy),      32'h0);
      chk("t6_rst_rdy",   32'(in_ready),  32'h0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("t6_no_done", 32'(done), 32'h0);
      chk("t6_idle",    32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
